// File: rtl/user_prj_stream_xfer.sv
// ---------------------------------------------------------------------------
// user_prj_stream_xfer
//
// AXI-Stream frame buffer for the FSIC user-project slot. A command beat on
// the slave stream (tdata[3:2]==2'b01) latches the reorder mode (tdata[1:0])
// and the frame length N (tdata[31:16]). Up to pDEPTH words are then captured
// into a register buffer and replayed on the master stream, forward (modes
// 0/2) or reversed (modes 1/3). After the frame the block parks in DONE until
// software writes 1 to bit 0 of register 0x000.
//
// Optional feature macro: USER_PRJ_XFER_HALFSWAP_EN
//   defined   -> modes 2/3 also swap the upper and lower data halves
//   undefined -> modes 2/3 replay exactly like modes 0/1
//
// Ports
//   axi_clk, axi_reset_n      : clock, synchronous active-low reset
//   aw*/w*                    : AXI-Lite write (awready=wready=awvalid&wvalid)
//   ar*/r*                    : AXI-Lite read, registered rvalid/rdata
//   ss_*                      : slave stream (command + frame data in)
//   sm_*                      : master stream (frame data out)
//   low__pri_irq              : irq_en & frame done
//   High_pri_req              : tied low
//   la_data_o                 : debug probe (handshakes, state, drain index)
//
// Register map: 0x000 status/restart, 0x004 irq_en, 0x008 frame_cnt,
//               0x00C last_len.
// ---------------------------------------------------------------------------
module user_prj_stream_xfer #(
  parameter int pADDR_WIDTH                  = 12,
  parameter int pDATA_WIDTH                  = 32,
  parameter int pDEPTH                       = 64,
  parameter int pUSER_PROJECT_SIDEBAND_WIDTH = 5
) (
  input  logic                                    axi_clk,
  input  logic                                    axi_reset_n,
  input  logic                                    awvalid,
  output logic                                    awready,
  input  logic [pADDR_WIDTH-1:0]                  awaddr,
  input  logic                                    wvalid,
  output logic                                    wready,
  input  logic [pDATA_WIDTH-1:0]                  wdata,
  input  logic [3:0]                              wstrb,
  input  logic                                    arvalid,
  output logic                                    arready,
  input  logic [pADDR_WIDTH-1:0]                  araddr,
  output logic                                    rvalid,
  input  logic                                    rready,
  output logic [pDATA_WIDTH-1:0]                  rdata,
  input  logic                                    ss_tvalid,
  input  logic [pDATA_WIDTH-1:0]                  ss_tdata,
  input  logic                                    ss_tlast,
  output logic                                    ss_tready,
  output logic                                    sm_tvalid,
  output logic [pDATA_WIDTH-1:0]                  sm_tdata,
  output logic                                    sm_tlast,
  input  logic                                    sm_tready,
  output logic [2:0]                              sm_tid,
  output logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] sm_tupsb,
  output logic [3:0]                              sm_tstrb,
  output logic [3:0]                              sm_tkeep,
  output logic                                    low__pri_irq,
  output logic                                    High_pri_req,
  output logic [23:0]                             la_data_o
);

  localparam int IDXW  = $clog2(pDEPTH);
  localparam int CNTW  = IDXW + 1;
  localparam int HALFW = pDATA_WIDTH / 2;

  localparam logic [1:0] ST_CMD   = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(12'h000);
  localparam logic [pADDR_WIDTH-1:0] ADDR_IRQ  = pADDR_WIDTH'(12'h004);
  localparam logic [pADDR_WIDTH-1:0] ADDR_CNT  = pADDR_WIDTH'(12'h008);
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(12'h00C);

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(pDEPTH);

  logic [1:0]             state_r;
  logic [1:0]             state_nxt_s;
  logic [1:0]             mode_r;
  logic [CNTW-1:0]        len_r;
  logic [CNTW-1:0]        wr_idx_r;
  logic [CNTW-1:0]        rd_idx_r;
  logic                   clamp_r;
  logic                   short_r;
  logic                   irq_en_r;
  logic [31:0]            frame_cnt_r;
  logic [CNTW-1:0]        last_len_r;
  logic                   rvalid_r;
  logic [pDATA_WIDTH-1:0] rdata_r;
  logic [pDATA_WIDTH-1:0] buf_r [pDEPTH];

  logic                   ss_tready_s;
  logic                   sm_tvalid_s;
  logic                   sm_tlast_s;
  logic                   busy_s;
  logic                   done_s;
  logic                   wr_hs_s;
  logic                   restart_s;
  logic                   ss_hs_s;
  logic                   sm_hs_s;
  logic                   cmd_hit_s;
  logic [15:0]            cmd_n_s;
  logic                   cmd_clamp_s;
  logic [CNTW-1:0]        wr_idx_inc_s;
  logic                   load_full_s;
  logic                   drain_last_s;
  logic [CNTW-1:0]        rd_addr_s;
  logic [pDATA_WIDTH-1:0] rd_word_s;
  logic [pDATA_WIDTH-1:0] rd_mux_s;
  logic                   unused_s;

  assign wr_hs_s      = awvalid & wvalid;
  assign restart_s    = wr_hs_s && (awaddr == ADDR_CTRL) && wdata[0] && (state_r == ST_DONE);
  assign ss_hs_s      = ss_tvalid & ss_tready_s;
  assign sm_hs_s      = sm_tvalid_s & sm_tready;
  assign cmd_hit_s    = (state_r == ST_CMD) && ss_hs_s && (ss_tdata[3:2] == 2'b01);
  assign cmd_n_s      = ss_tdata[31:16];
  assign cmd_clamp_s  = (cmd_n_s == 16'd0) || ({16'd0, cmd_n_s} > 32'(pDEPTH));
  assign wr_idx_inc_s = wr_idx_r + CNT_ONE;
  assign load_full_s  = (wr_idx_inc_s == len_r);
  assign drain_last_s = (rd_idx_r == (len_r - CNT_ONE));

  // Reversed modes walk the captured frame from its last word downwards.
  assign rd_addr_s = mode_r[0] ? (len_r - CNT_ONE - rd_idx_r) : rd_idx_r;
  assign rd_word_s = buf_r[rd_addr_s[IDXW-1:0]];

`ifdef USER_PRJ_XFER_HALFSWAP_EN
  assign sm_tdata = mode_r[1] ? {rd_word_s[HALFW-1:0], rd_word_s[pDATA_WIDTH-1:HALFW]}
                              : rd_word_s;
`else
  assign sm_tdata = rd_word_s;
`endif

  // State register.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      state_r <= ST_CMD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CMD: begin
        if (cmd_hit_s) state_nxt_s = ST_LOAD;
        else           state_nxt_s = ST_CMD;
      end
      ST_LOAD: begin
        if (ss_hs_s && (load_full_s || ss_tlast)) state_nxt_s = ST_DRAIN;
        else                                      state_nxt_s = ST_LOAD;
      end
      ST_DRAIN: begin
        if (sm_hs_s && drain_last_s) state_nxt_s = ST_DONE;
        else                         state_nxt_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (restart_s) state_nxt_s = ST_CMD;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_CMD;
    endcase
  end

  // Per-state stream handshake and status outputs.
  always_comb begin
    ss_tready_s = 1'b0;
    sm_tvalid_s = 1'b0;
    sm_tlast_s  = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_CMD:   ss_tready_s = 1'b1;
      ST_LOAD: begin
        ss_tready_s = 1'b1;
        busy_s      = 1'b1;
      end
      ST_DRAIN: begin
        sm_tvalid_s = 1'b1;
        sm_tlast_s  = drain_last_s;
        busy_s      = 1'b1;
      end
      ST_DONE:  done_s = 1'b1;
      default:  done_s = 1'b0;
    endcase
  end

  // Frame bookkeeping: mode, length, indices, sticky flags, counters.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      mode_r      <= 2'b00;
      len_r       <= '0;
      wr_idx_r    <= '0;
      rd_idx_r    <= '0;
      clamp_r     <= 1'b0;
      short_r     <= 1'b0;
      frame_cnt_r <= 32'd0;
      last_len_r  <= '0;
    end else begin
      case (state_r)
        ST_CMD: begin
          if (cmd_hit_s) begin
            mode_r   <= ss_tdata[1:0];
            wr_idx_r <= '0;
            rd_idx_r <= '0;
            if (cmd_clamp_s) begin
              len_r   <= DEPTH_C;
              clamp_r <= 1'b1;
            end else begin
              len_r   <= CNTW'(cmd_n_s);
            end
          end
        end
        ST_LOAD: begin
          if (ss_hs_s) begin
            wr_idx_r <= wr_idx_inc_s;
            // Early tlast shrinks the frame to the words actually received.
            if (ss_tlast && !load_full_s) begin
              len_r   <= wr_idx_inc_s;
              short_r <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (sm_hs_s) begin
            rd_idx_r <= rd_idx_r + CNT_ONE;
            if (drain_last_s) begin
              frame_cnt_r <= frame_cnt_r + 32'd1;
              last_len_r  <= len_r;
            end
          end
        end
        ST_DONE: begin
          if (restart_s) begin
            clamp_r <= 1'b0;
            short_r <= 1'b0;
          end
        end
        default: mode_r <= mode_r;
      endcase
    end
  end

  // Frame buffer storage; contents deliberately survive reset.
  always_ff @(posedge axi_clk) begin
    if ((state_r == ST_LOAD) && ss_hs_s) begin
      buf_r[wr_idx_r[IDXW-1:0]] <= ss_tdata;
    end
  end

  // Interrupt enable register.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      irq_en_r <= 1'b0;
    end else if (wr_hs_s && (awaddr == ADDR_IRQ)) begin
      irq_en_r <= wdata[0];
    end
  end

  // Read data select from the current (pre-write) register values.
  always_comb begin
    rd_mux_s = {pDATA_WIDTH{1'b0}};
    case (araddr)
      ADDR_CTRL: rd_mux_s = pDATA_WIDTH'({26'd0, mode_r, short_r, clamp_r, busy_s, done_s});
      ADDR_IRQ:  rd_mux_s = pDATA_WIDTH'(irq_en_r);
      ADDR_CNT:  rd_mux_s = pDATA_WIDTH'(frame_cnt_r);
      ADDR_LEN:  rd_mux_s = pDATA_WIDTH'(last_len_r);
      default:   rd_mux_s = {pDATA_WIDTH{1'b0}};
    endcase
  end

  // Read response channel: one outstanding read, held until rready.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      rvalid_r <= 1'b0;
      rdata_r  <= {pDATA_WIDTH{1'b0}};
    end else if (arvalid && !rvalid_r) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_mux_s;
    end else if (rvalid_r && rready) begin
      rvalid_r <= 1'b0;
    end
  end

  assign awready      = wr_hs_s;
  assign wready       = wr_hs_s;
  assign arready      = !rvalid_r;
  assign rvalid       = rvalid_r;
  assign rdata        = rdata_r;
  assign ss_tready    = ss_tready_s;
  assign sm_tvalid    = sm_tvalid_s;
  assign sm_tlast     = sm_tlast_s;
  assign sm_tid       = 3'b000;
  assign sm_tupsb     = {pUSER_PROJECT_SIDEBAND_WIDTH{1'b0}};
  assign sm_tstrb     = 4'hF;
  assign sm_tkeep     = 4'hF;
  assign low__pri_irq = irq_en_r & (state_r == ST_DONE);
  assign High_pri_req = 1'b0;
  assign la_data_o    = {awvalid, wr_hs_s, wvalid, wr_hs_s, arvalid, !rvalid_r, rready, rvalid_r,
                         ss_tvalid, ss_tready_s, sm_tvalid_s, sm_tready,
                         state_r, 10'(rd_idx_r)};

  assign unused_s = ^{wstrb, wdata[pDATA_WIDTH-1:1], rd_addr_s[IDXW]};

endmodule
